// File: rtl/tmr_scrub_ctrl.sv
// -----------------------------------------------------------------------------
// tmr_scrub_ctrl
// Access controller sitting directly in front of a TMR SRAM (three copies plus
// a majority voter). Host reads/writes are arbitrated against a background
// scrubber that reads each address through the voter and writes the voted word
// back to all copies, so a single-copy upset is repaired before a second upset
// at the same address can defeat the vote.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   scrub_en          enables the period counter and new scrub starts
//   host_req/we/addr/wdata   host request, held by the host until granted
//   host_gnt          request accepted this cycle (combinational)
//   host_rvalid/rdata read data, one cycle after a read grant (0 otherwise)
//   mem_enable/we/addr/wdata  combinational drive to the TMR memory
//   mem_rdata         voted memory output, valid the cycle after a read
//   scrub_addr        next address to be scrubbed
//   pass_done         1-cycle pulse after the last address was written back
//   busy              controller is not idle
// -----------------------------------------------------------------------------
module tmr_scrub_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int SCRUB_PERIOD = 256,
  parameter int MAX_DEFER    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scrub_en,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_enable,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] scrub_addr,
  output logic              pass_done,
  output logic              busy
);

  localparam int CNT_W = (SCRUB_PERIOD > 2) ? $clog2(SCRUB_PERIOD) : 1;
  localparam int DEF_W = $clog2(MAX_DEFER + 1);

  // The counter wraps when its next value would be SCRUB_PERIOD-1, so it
  // only ever holds 0 .. SCRUB_PERIOD-2.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCRUB_PERIOD - 2);
  localparam logic [DEF_W-1:0] DEFER_MAX = DEF_W'(MAX_DEFER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_H_RD = 2'd1,
    ST_S_RD = 2'd2,
    ST_S_WB = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_period_cnt;
  logic [DEF_W-1:0]  r_defer_cnt;
  logic              r_scrub_pending;
  logic [ADDR_W-1:0] r_scrub_addr;
  logic              r_pass_done;

  logic              w_idle;
  logic              w_start_scrub;
  logic              w_host_grant;

  assign w_idle = (r_state == ST_IDLE);

  // A pending scrub waits for a host-free cycle unless host traffic has
  // already deferred it MAX_DEFER times; scrub_en=0 blocks new starts.
  assign w_start_scrub = w_idle && scrub_en && r_scrub_pending &&
                         (!host_req || (r_defer_cnt == DEFER_MAX));

  // Gated by rst_n so the grant (and thus mem_enable) drops the instant
  // reset is asserted, even while the host holds its request.
  assign w_host_grant = rst_n && w_idle && host_req && !w_start_scrub;

  // Period counter and scrub_pending flag: count idle cycles, raise a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_cnt    <= '0;
      r_scrub_pending <= 1'b0;
    end else if (r_state == ST_S_WB) begin
      r_scrub_pending <= 1'b0;
    end else if (scrub_en && !r_scrub_pending) begin
      if (r_period_cnt == CNT_LAST) begin
        r_period_cnt    <= '0;
        r_scrub_pending <= 1'b1;
      end else begin
        r_period_cnt <= r_period_cnt + CNT_W'(1);
      end
    end else begin
      r_period_cnt <= r_period_cnt;
    end
  end

  // Defer counter: host grants taken while a scrub is waiting, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_defer_cnt <= '0;
    end else if (w_start_scrub) begin
      r_defer_cnt <= '0;
    end else if (r_scrub_pending && w_idle && host_req &&
                 (r_defer_cnt != DEFER_MAX)) begin
      r_defer_cnt <= r_defer_cnt + DEF_W'(1);
    end else begin
      r_defer_cnt <= r_defer_cnt;
    end
  end

  // Main FSM, scrub address walk and end-of-pass pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_scrub_addr <= '0;
      r_pass_done  <= 1'b0;
    end else begin
      r_pass_done <= (r_state == ST_S_WB) && (r_scrub_addr == {ADDR_W{1'b1}});
      case (r_state)
        ST_IDLE: begin
          if (w_start_scrub) begin
            r_state <= ST_S_RD;
          end else if (w_host_grant && !host_we) begin
            r_state <= ST_H_RD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_H_RD: r_state <= ST_IDLE;
        ST_S_RD: r_state <= ST_S_WB;
        ST_S_WB: begin
          r_state      <= ST_IDLE;
          r_scrub_addr <= r_scrub_addr + ADDR_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory and host-side drive decoded from the current state.
  always_comb begin
    host_gnt    = 1'b0;
    host_rvalid = 1'b0;
    host_rdata  = '0;
    mem_enable  = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_host_grant) begin
          host_gnt   = 1'b1;
          mem_enable = 1'b1;
          mem_we     = host_we;
          mem_addr   = host_addr;
          mem_wdata  = host_wdata;
        end else begin
          host_gnt   = 1'b0;
        end
      end
      ST_H_RD: begin
        host_rvalid = 1'b1;
        host_rdata  = mem_rdata;
      end
      ST_S_RD: begin
        mem_enable = 1'b1;
        mem_addr   = r_scrub_addr;
      end
      ST_S_WB: begin
        // Write the voted word from the S_RD read back to every copy.
        mem_enable = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = r_scrub_addr;
        mem_wdata  = mem_rdata;
      end
      default: begin
        mem_enable = 1'b0;
      end
    endcase
  end

  assign scrub_addr = r_scrub_addr;
  assign pass_done  = r_pass_done;
  assign busy       = !w_idle;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tmr_scrub_ctrl
// Self-checking bench for tmr_scrub_ctrl. Contains a behavioural TMR SRAM
// (three copies + voter) and a transaction-level reference: an array holding
// the value the host last wrote to every address. Host reads must return that
// value; every scrub must walk addresses in order and write back that value.
// -----------------------------------------------------------------------------
module tb_tmr_scrub_ctrl;

  logic       clk;
  logic       rst_n;
  logic       scrub_en;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  logic       mem_enable;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] scrub_addr;
  logic       pass_done;
  logic       busy;

  tmr_scrub_ctrl #(
    .ADDR_W(8), .DATA_W(8), .SCRUB_PERIOD(4), .MAX_DEFER(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .mem_enable(mem_enable), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .scrub_addr(scrub_addr), .pass_done(pass_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- TMR memory model ----------------
  logic [7:0] mem_c1 [256];
  logic [7:0] mem_c2 [256];
  logic [7:0] mem_c3 [256];
  logic       mem_clear;
  logic       cor_en;
  int         cor_copy;
  logic [7:0] cor_addr;
  logic [7:0] cor_val;

  function automatic logic [7:0] vote(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) begin
        mem_c1[i] <= 8'h00; mem_c2[i] <= 8'h00; mem_c3[i] <= 8'h00;
      end
      mem_rdata <= 8'h00;
    end else begin
      if (mem_enable) begin
        if (mem_we) begin
          mem_c1[mem_addr] <= mem_wdata;
          mem_c2[mem_addr] <= mem_wdata;
          mem_c3[mem_addr] <= mem_wdata;
        end else begin
          mem_rdata <= vote(mem_c1[mem_addr], mem_c2[mem_addr], mem_c3[mem_addr]);
        end
      end
      if (cor_en) begin
        case (cor_copy)
          1:       mem_c1[cor_addr] <= cor_val;
          2:       mem_c2[cor_addr] <= cor_val;
          default: mem_c3[cor_addr] <= cor_val;
        endcase
      end
    end
  end

  // ---------------- reference model and checking ----------------
  logic [7:0] model [256];
  logic [7:0] exp_scrub;
  logic       rd_exp_v;
  logic [7:0] rd_exp_d;
  int         n_checks;
  int         n_errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle scoreboard, evaluated on the falling edge.
  task automatic mon();
    if (!rst_n) begin
      rd_exp_v  = 1'b0;
      exp_scrub = 8'h00;
      return;
    end
    check("rvalid", 32'(host_rvalid), 32'(rd_exp_v));
    if (host_rvalid) check("rdata", 32'(host_rdata), 32'(rd_exp_d));
    else             check("rdata_zero", 32'(host_rdata), 32'h0);
    rd_exp_v = 1'b0;
    if (!mem_enable) check("mem_quiet", 32'({mem_we, mem_addr, mem_wdata}), 32'h0);
    check("scrub_addr_port", 32'(scrub_addr), 32'(exp_scrub));
    if (host_gnt) begin
      check("gnt_mem", 32'({mem_enable, mem_we, mem_addr}), 32'({1'b1, host_we, host_addr}));
      if (host_we) begin
        model[host_addr] = host_wdata;
      end else begin
        rd_exp_v = 1'b1;
        rd_exp_d = model[host_addr];
      end
    end else if (mem_enable) begin
      check("scrub_mem_addr", 32'(mem_addr), 32'(exp_scrub));
      if (mem_we) begin
        check("scrub_wb_data", 32'(mem_wdata), 32'(model[mem_addr]));
        exp_scrub = exp_scrub + 8'd1;
      end
    end
  endtask

  // One clock: monitor at negedge, return 1 time unit after the next posedge.
  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] d,
                         output int waits);
    logic g;
    g = 1'b0; waits = 0;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    while (!g && waits < 200) begin
      #2;
      g = host_gnt;
      step();
      if (!g) waits++;
    end
    host_req = 1'b0; host_we = 1'b0;
    if (!g) check("host_gnt_timeout", 32'(g), 32'h1);
  endtask

  task automatic corrupt(input int copy, input logic [7:0] a, input logic [7:0] v);
    cor_en = 1'b1; cor_copy = copy; cor_addr = a; cor_val = v;
    step();
    cor_en = 1'b0;
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int waits, last, nrd, npd, nsc, grants, first, quiet, r;
    logic prev_rd, prev_wb, g, found;
    logic [7:0] rd_addr, bad, a;

    vecs[0] = '{1'b1, 8'd10, 8'h2C, 8'h00};
    vecs[1] = '{1'b1, 8'd20, 8'h3C, 8'h00};
    vecs[2] = '{1'b1, 8'd30, 8'hA5, 8'h00};
    vecs[3] = '{1'b0, 8'd10, 8'h00, 8'h2C};
    vecs[4] = '{1'b0, 8'd20, 8'h00, 8'h3C};
    vecs[5] = '{1'b0, 8'd30, 8'h00, 8'hA5};

    n_checks = 0; n_errors = 0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    rd_exp_v = 1'b0; rd_exp_d = 8'h00; exp_scrub = 8'h00;
    cor_en = 1'b0; cor_copy = 1; cor_addr = 8'h00; cor_val = 8'h00;

    // Reset with the host already requesting: every output must stay 0.
    rst_n = 1'b0; mem_clear = 1'b1; scrub_en = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h55;
    #3;
    check("reset_ctrl", 32'({host_gnt, host_rvalid, mem_enable, mem_we, pass_done, busy}), 32'h0);
    check("reset_data", {host_rdata, mem_addr, mem_wdata, scrub_addr}, 32'h0);
    step(); step();
    mem_clear = 1'b0; host_req = 1'b0; host_we = 1'b0; scrub_en = 1'b0; rst_n = 1'b1;
    #2;
    check("post_reset_ctrl", 32'({host_gnt, host_rvalid, mem_enable, busy}), 32'h0);
    step();

    // Test 1: table-driven host writes then reads, scrubbing disabled.
    for (int i = 0; i < 6; i++) begin
      host_op(vecs[i].we, vecs[i].addr, vecs[i].data, waits);
      check("t1_gnt_latency", 32'(waits), 32'h0);
      if (!vecs[i].we) begin
        #2;
        check("t1_rvalid", 32'(host_rvalid), 32'h1);
        check("t1_rdata", 32'(host_rdata), 32'(vecs[i].exp));
        step();
      end
    end
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      #2; if (mem_enable) quiet++;
      step();
    end
    check("t1_idle_no_mem", 32'(quiet), 32'h0);

    // Upsets for test 3: one bad copy at each of two addresses.
    corrupt(1, 8'd10, 8'h00);
    corrupt(3, 8'd30, 8'h00);

    // Test 2: a full scrub pass with no host traffic.
    scrub_en = 1'b1; last = -1; nrd = 0; npd = 0; prev_rd = 1'b0; rd_addr = 8'h00;
    for (int c = 0; c < 2000 && npd == 0; c++) begin
      #2;
      if (prev_rd) check("t2_swb_follows", 32'({mem_enable, mem_we, busy, mem_addr}),
                         32'({3'b111, rd_addr}));
      prev_rd = 1'b0;
      if (pass_done) begin
        npd++;
        check("t2_pass_after_256", 32'(nrd), 32'd256);
        check("t2_scrub_addr_wrap", 32'(scrub_addr), 32'h0);
      end
      if (mem_enable && !mem_we && busy) begin
        if (last >= 0) check("t2_scrub_gap", 32'(c - last), 32'd6);
        last = c; rd_addr = mem_addr; prev_rd = 1'b1; nrd++;
      end
      step();
    end
    check("t2_pass_seen", 32'(npd), 32'h1);
    #2;
    check("t2_pass_one_pulse", 32'(pass_done), 32'h0);
    scrub_en = 1'b0;
    step();

    // Test 3: the pass must have repaired every copy.
    check("t3_c1_10", 32'(mem_c1[10]), 32'h2C);
    check("t3_c2_10", 32'(mem_c2[10]), 32'h2C);
    check("t3_c3_10", 32'(mem_c3[10]), 32'h2C);
    check("t3_c1_30", 32'(mem_c1[30]), 32'hA5);
    check("t3_c2_30", 32'(mem_c2[30]), 32'hA5);
    check("t3_c3_30", 32'(mem_c3[30]), 32'hA5);

    // Test 4: continuous host reads. After a write-back the period needs three
    // counting cycles (two read grants), then 16 deferring grants, then the scrub.
    scrub_en = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 8'($urandom);
    nsc = 0; grants = 0; prev_wb = 1'b0;
    for (int c = 0; c < 600 && nsc < 4; c++) begin
      #2;
      if (prev_wb) check("t4_gnt_after_wb", 32'(host_gnt), 32'h1);
      prev_wb = 1'b0;
      if (busy && mem_enable) begin
        check("t4_gnt_blocked", 32'(host_gnt), 32'h0);
        if (!mem_we) begin
          if (nsc > 0) check("t4_defer_grants", 32'(grants), 32'd18);
          nsc++; grants = 0;
        end else begin
          prev_wb = 1'b1;
        end
      end
      g = host_gnt;
      if (g) grants++;
      step();
      if (g) host_addr = 8'($urandom);
    end
    host_req = 1'b0;
    check("t4_scrubs_seen", 32'(nsc), 32'd4);
    step(); step();

    // Test 5: reset while scrubbing address 5 abandons the write-back.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    #2; check("t5_restart_addr", 32'(scrub_addr), 32'h0);
    step();
    bad = ~model[5];
    corrupt(2, 8'd5, bad);
    scrub_en = 1'b1; found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      #2;
      if (busy && mem_enable && !mem_we && mem_addr == 8'd5) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("t5_reached_addr5", 32'(found), 32'h1);
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd5; host_wdata = 8'h77;
    rst_n = 1'b0;
    #1;
    check("t5_async_ctrl", 32'({host_gnt, host_rvalid, mem_enable, mem_we, pass_done, busy}), 32'h0);
    check("t5_async_data", {host_rdata, mem_addr, mem_wdata, scrub_addr}, 32'h0);
    step();
    host_req = 1'b0; host_we = 1'b0;
    step();
    check("t5_no_writeback", 32'(mem_c2[5]), 32'(bad));
    rst_n = 1'b1;
    #2;
    check("t5_release_addr", 32'({busy, scrub_addr}), 32'h0);
    step();
    corrupt(2, 8'd5, model[5]);

    // Test 6: dropping scrub_en in S_RD still finishes the step, then freezes.
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #2;
      if (busy && mem_enable && !mem_we) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("t6_found_srd", 32'(found), 32'h1);
    scrub_en = 1'b0;
    step();
    #2;
    check("t6_swb_completes", 32'({mem_enable, mem_we, busy}), 32'h7);
    step();
    quiet = 0;
    for (int i = 0; i < 30; i++) begin
      #2; if (mem_enable) quiet++;
      step();
    end
    check("t6_frozen", 32'(quiet), 32'h0);
    // Re-enabled from a zero counter: three counting cycles, one IDLE, S_RD.
    scrub_en = 1'b1; first = -1;
    for (int i = 0; i < 12; i++) begin
      #2;
      if (first < 0 && busy && mem_enable && !mem_we) first = i;
      step();
    end
    check("t6_reenable_latency", 32'(first), 32'd4);

    // Randomised traffic, scrub_en toggling and single-copy upsets.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0) scrub_en = ~scrub_en;
      if (r == 1) begin
        a = 8'($urandom);
        if (mem_c1[a] == mem_c2[a] && mem_c2[a] == mem_c3[a])
          corrupt($urandom_range(1, 3), a, ~mem_c1[a]);
      end else if (r < 4) begin
        repeat ($urandom_range(1, 5)) step();
      end else begin
        host_op(1'($urandom), 8'($urandom), 8'($urandom), waits);
      end
    end
    host_req = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tmr_scrub_ctrl.md
Name: tmr_scrub_ctrl

Overview:
Access controller placed directly upstream of the TMR SRAM top (three 256x8 copies plus majority voter). It arbitrates host read/write requests against a background scrubber. The scrubber periodically reads each address through the voter and writes the voted word back to all three copies, so single-copy upsets are corrected before a second upset can defeat the vote. It drives the memory's enable/we/addr/data_in and consumes its voted data_out.

Parameters:
ADDR_W, 8, address width; scrub walks 0 .. 2^ADDR_W-1
DATA_W, 8, data width
SCRUB_PERIOD, 256, idle cycles between scrub steps (>=2)
MAX_DEFER, 16, cycles a pending scrub may be deferred by host traffic before it pre-empts (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
scrub_en  in  1  enables period counter and scrubbing
host_req  in  1  host request; held until granted
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  request accepted this cycle (combinational)
host_rvalid  out  1  read data valid (1 cycle after read grant)
host_rdata  out  DATA_W  read data; 0 when host_rvalid=0
mem_enable  out  1  to TMR top enable
mem_we  out  1  to TMR top we
mem_addr  out  ADDR_W  to TMR top addr
mem_wdata  out  DATA_W  to TMR top data_in
mem_rdata  in  DATA_W  voted data_out; valid the cycle after a read is sampled
scrub_addr  out  ADDR_W  next address to scrub
pass_done  out  1  1-cycle pulse when address 2^ADDR_W-1 has been written back
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0; scrub_addr=0; period counter, defer counter and scrub_pending cleared. Reset in the middle of a scrub abandons it and performs no write-back. Scrub restarts at address 0.
- mem_* are combinational from state/inputs. The memory samples them at the cycle-ending edge. mem_enable=0 implies mem_we=0, and mem_addr/mem_wdata=0.
- Period counter: increments each cycle while scrub_en=1 and scrub_pending=0. On reaching SCRUB_PERIOD-1 it sets scrub_pending and wraps to 0. scrub_en=0 holds the counter and blocks new scrub starts. A step already started always completes.
- Defer counter: increments each cycle scrub_pending=1 and state=IDLE and host_req=1. Clears when a scrub starts. Saturates at MAX_DEFER.
- FSM states:
  - IDLE:
    - If scrub_pending and (host_req=0 or defer==MAX_DEFER): go to S_RD. host_gnt=0.
    - Else if host_req: host_gnt=1, mem_enable=1, mem_we=host_we, addr/wdata from host. A read goes to H_RD; a write stays in IDLE, so back-to-back writes run 1 per cycle.
  - H_RD: host_gnt=0, mem_enable=0. host_rvalid=1 and host_rdata=mem_rdata. Go to IDLE. Read throughput is 1 per 2 cycles.
  - S_RD: mem_enable=1, mem_we=0, mem_addr=scrub_addr. Go to S_WB.
  - S_WB: mem_enable=1, mem_we=1, mem_addr=scrub_addr, mem_wdata=mem_rdata (voted). Then scrub_addr increments mod 2^ADDR_W, scrub_pending clears, go to IDLE. pass_done=1 in the cycle after the S_WB edge when the written address was 2^ADDR_W-1.
- host_gnt is 0 in every state other than IDLE. Host requests presented during S_RD/S_WB/H_RD stall and must be held by the host.
- The host never observes scrub read data; host_rvalid is asserted only for host reads.
- A host write to scrub_addr in the same window as its scrub cannot occur, because the scrub pair is atomic.

Test Plan:
1. Reset, scrub_en=0. Host write addr 10=0x2C, 20=0x3C, 30=0xA5, then read each. Required: host_gnt same cycle; host_rvalid one cycle later with 0x2C/0x3C/0xA5; no mem access while idle.
2. SCRUB_PERIOD=4, scrub_en=1, no host traffic. Required: S_RD/S_WB pairs every 6 cycles, addresses 0,1,2…; after address 255, pass_done pulses once and scrub_addr=0.
3. Force copy 1 at addr 10 to 0x00 and copy 3 at addr 30 to 0x00. Let the scrubber pass over them. Required: all three copies read 0x2C and 0xA5 afterwards, checked hierarchically per copy.
4. Continuous host_req reads with scrub_pending, MAX_DEFER=16. Required: scrub starts exactly when the defer count reaches 16; host_gnt is 0 for the two scrub cycles; the held request is granted in the following IDLE cycle.
5. Assert rst_n=0 during S_RD at scrub_addr=5. Required: all outputs 0 immediately (async); no write-back to address 5; scrub_addr=0 after release.
6. Deassert scrub_en mid-S_RD. Required: S_WB still completes; the period counter freezes; no further scrubs until re-enabled.
